// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive buffer: default sizing and the
// layout of one buffered entry.
package uart_rx_fifo_pkg;

    // Default number of buffered entries (power of two, at least 2).
    localparam int DEPTH_DEFAULT  = 16;

    // Default width of the saturating dropped-byte counter.
    localparam int DROP_W_DEFAULT = 8;

    // Pointer width derived from the default depth.
    localparam int ADDR_W_DEFAULT = $clog2(DEPTH_DEFAULT);

    // One buffered byte together with its framing/parity error flag.
    typedef struct packed {
        logic       error;
        logic [7:0] data;
    } entry_t;

    // Storage width of one entry.
    localparam int ENTRY_W = $bits(entry_t);

endpackage : uart_rx_fifo_pkg

// File: rtl/uart_fifo_ram.sv
// Register-array storage for the receive buffer: one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset; the
// pointer/count logic in the top decides which words are meaningful.
module uart_fifo_ram
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Write the incoming entry on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read of the addressed word (first-word-fall-through head).
    always_comb begin
        rd_data = mem[rd_addr];
    end

endmodule : uart_fifo_ram

// File: rtl/uart_rx_fifo.sv
// Receive buffer placed directly after the UART receiver. Every byte strobe
// is captured with its error flag into a first-word-fall-through FIFO. The
// receiver cannot be stalled, so bytes arriving while the buffer is full are
// lost; that loss is recorded in a sticky overflow flag and a saturating
// drop counter. Errored bytes may optionally be discarded at the input.
//
// Output handshake: io_out_valid/io_out_bits_* present the head entry; an
// entry is consumed on a rising edge where io_out_valid and io_out_ready are
// both 1. While io_out_valid=1 and io_out_ready=0 the head entry is held
// stable. io_out_valid never depends on io_out_ready.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int DROP_W = DROP_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    io_in_valid,
    input  logic [7:0]              io_in_bits_data,
    input  logic                    io_in_bits_error,
    input  logic                    io_config_dropErrors,
    output logic                    io_out_valid,
    input  logic                    io_out_ready,
    output logic [7:0]              io_out_bits_data,
    output logic                    io_out_bits_error,
    output logic [$clog2(DEPTH):0]  io_count,
    output logic                    io_overflow,
    output logic [DROP_W-1:0]       io_dropCount,
    input  logic                    io_clearOverflow
);

    localparam int                ADDR_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic [ADDR_W:0]   cnt;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    logic              push_req;
    logic              pop;
    logic              full;
    logic              push_ok;
    logic              overrun;

    entry_t             wr_entry;
    entry_t             head;
    logic [ENTRY_W-1:0] rd_word;

    // Decide what happens this cycle: accepted push, pop and overrun.
    always_comb begin
        push_req = io_in_valid & ~(io_config_dropErrors & io_in_bits_error);
        pop      = io_out_valid & io_out_ready;
        full     = (cnt == FULL_CNT);
        // A full buffer still accepts a byte when the head leaves in the same cycle.
        push_ok  = push_req & (~full | pop);
        overrun  = push_req & full & ~pop;
        wr_entry.error = io_in_bits_error;
        wr_entry.data  = io_in_bits_data;
    end

    // Write pointer advances on every accepted push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
        end else if (push_ok) begin
            wp <= wp + PTR_ONE;
        end
    end

    // Read pointer advances on every pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rp <= '0;
        end else if (pop) begin
            rp <= rp + PTR_ONE;
        end
    end

    // Occupancy tracks accepted pushes minus pops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (push_ok && !pop) begin
            cnt <= cnt + CNT_ONE;
        end else if (!push_ok && pop) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    // Sticky overflow flag; a same-cycle overrun takes priority over a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (overrun) begin
            overflow <= 1'b1;
        end else if (io_clearOverflow) begin
            overflow <= 1'b0;
        end
    end

    // Saturating count of bytes lost to overrun; a clear coinciding with an
    // overrun restarts the count at one so the new loss is not hidden.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (overrun) begin
            if (io_clearOverflow) begin
                drop_cnt <= DROP_ONE;
            end else if (drop_cnt != DROP_MAX) begin
                drop_cnt <= drop_cnt + DROP_ONE;
            end
        end else if (io_clearOverflow) begin
            drop_cnt <= '0;
        end
    end

    uart_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_addr (wp),
        .wr_data (wr_entry),
        .rd_addr (rp),
        .rd_data (rd_word)
    );

    // Present the head entry and status registers.
    always_comb begin
        head              = entry_t'(rd_word);
        io_out_valid      = (cnt != '0);
        io_out_bits_data  = head.data;
        io_out_bits_error = head.error;
        io_count          = cnt;
        io_overflow       = overflow;
        io_dropCount      = drop_cnt;
    end

endmodule : uart_rx_fifo

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer that sits directly downstream of the UART receiver. Captures every single-cycle byte strobe the receiver emits, together with its framing/parity error flag, and holds the entries in a first-word-fall-through FIFO behind a valid/ready interface for the bus-side consumer. The receiver cannot be back-pressured, so the block also detects overrun, counts dropped bytes, and can optionally discard errored bytes.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥ 2
- DROP_W, 8, width of the dropped-byte counter

Ports:
- clk  in  1  sole clock; all state on rising edge
- reset  in  1  reset, asynchronous, active-low (asserted at 0); one clock, reset is asynchronous and active-low
- io_in_valid  in  1  single-cycle byte strobe from the receiver
- io_in_bits_data  in  8  received byte
- io_in_bits_error  in  1  framing/parity error for that byte
- io_config_dropErrors  in  1  1 = discard bytes with io_in_bits_error=1
- io_out_valid  out  1  head entry available
- io_out_ready  in  1  consumer accepts head entry
- io_out_bits_data  out  8  head byte
- io_out_bits_error  out  1  head error flag
- io_count  out  log2(DEPTH)+1  current occupancy
- io_overflow  out  1  sticky overrun flag
- io_dropCount  out  DROP_W  bytes lost to overrun, saturating
- io_clearOverflow  in  1  synchronous clear of io_overflow and io_dropCount

## Operation
- Storage: DEPTH × 9 bits {error, data}; write pointer wp, read pointer rp, each log2(DEPTH) bits, wrap naturally modulo DEPTH; occupancy cnt, log2(DEPTH)+1 bits.
- push_req = io_in_valid & ~(io_config_dropErrors & io_in_bits_error).
- pop = io_out_valid & io_out_ready.
- push accepted when push_req & (cnt < DEPTH | pop); writes mem[wp], wp+1.
- pop: rp+1. cnt += accepted push − pop.
- Full with simultaneous pop and push: both occur, cnt stays DEPTH, no overrun.
- Empty with push: no bypass; io_out_valid is 0 that cycle, so no pop.
- Overrun: push_req & cnt==DEPTH & ~pop → byte discarded, io_overflow←1, io_dropCount +1 saturating at 2^DROP_W−1.
- io_clearOverflow: io_overflow←0, io_dropCount←0; if an overrun occurs the same cycle, overrun wins: io_overflow=1, io_dropCount=1.
- Bytes discarded by io_config_dropErrors do not count as overrun and do not touch io_dropCount.
- Outputs: io_out_valid = (cnt != 0); io_out_bits_* = mem[rp] (combinational read of registered storage); io_count = cnt.
- Head data is held stable while io_out_valid=1 and io_out_ready=0.

## Timing
- Reset (async assert, deasserted synchronously upstream): wp=rp=0, cnt=0, io_out_valid=0, io_count=0, io_overflow=0, io_dropCount=0; io_out_bits_* undefined-but-don't-care while io_out_valid=0 (implementation drives mem[0]; memory not reset).
- Reset mid-operation: all buffered contents are lost immediately; no partial entries survive.
- Latency: byte strobed in cycle N appears at the head in cycle N+1 when FIFO was empty.
- io_count, io_overflow, io_dropCount are registered and update one cycle after the causing event.
- io_in_valid is taken as a one-cycle pulse; back-to-back strobes every cycle must be absorbed with no loss until full.

## Structure
- Shared package: DEPTH default, DROP_W default, entry type {error:1, data:8}, derived ADDR_W = log2(DEPTH).
- One sub-module: uart_fifo_ram (DEPTH×9 register array, one write port, one asynchronous read port, no reset).
- Pointer/count/overflow logic lives in the top.

## Test plan
- Reset, push 0x41, 0x42, 0x43 with error=0, ready=1 → out 0x41, 0x42, 0x43 in order, each valid from one cycle after its strobe; io_count returns to 0.
- ready=0, push 16 bytes 0x00..0x0F → io_count=16; push 0x10 → io_overflow=1, io_dropCount=1; then drain → 0x00..0x0F, 0x10 absent.
- Full FIFO, push 0x55 in same cycle as pop → no overflow, io_count stays 16, 0x55 emerges last.
- dropErrors=1, push 0x11 err=1, 0x22 err=0 → only 0x22 output, io_dropCount=0; dropErrors=0, push 0x33 err=1 → out 0x33 with io_out_bits_error=1.
- Overrun 300 times with DROP_W=8 → io_dropCount=255; io_clearOverflow same cycle as further overrun → io_overflow=1, io_dropCount=1.
- Assert reset with 5 entries buffered → io_out_valid=0, io_count=0 immediately (asynchronously); after release, FIFO behaves as empty.
